baccarat_sequencer: RTL

//  Game-control FSM that drives the card datapath. Issues one-hot load strobes that deal four cards in the

---
 rtl/baccarat_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/baccarat_sequencer.sv
// Baccarat game-control FSM: deals four cards, applies the third-card rules
// for player and dealer, then holds the win lights until reset.
module baccarat_sequencer #(
  parameter logic [3:0] NATURAL_MIN = 4'd8,
  parameter logic [3:0] PLAYER_DRAW = 4'd5
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_over
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_P1    = 4'd1,
    S_D1    = 4'd2,
    S_P2    = 4'd3,
    S_D2    = 4'd4,
    S_EVAL  = 4'd5,
    S_P3    = 4'd6,
    S_BEVAL = 4'd7,
    S_D3    = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  // strobe vector order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
  state_t     state_q, state_d;
  logic [5:0] loads_q, loads_d;
  logic       done_q, done_d;
  logic       pwin_s, dwin_s;

  // Face cards and tens (codes 10..15) count as zero.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] card);
    logic [3:0] v;
    logic       draw;
    v = (card >= 4'd10) ? 4'd0 : card;
    case (ds)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  // Next-state logic for the deal and third-card decisions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_P1;
      S_P1:    state_d = S_D1;
      S_D1:    state_d = S_P2;
      S_P2:    state_d = S_D2;
      S_D2:    state_d = S_EVAL;
      S_EVAL: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_d = S_DONE;
        end else if (pscore <= PLAYER_DRAW) begin
          state_d = S_P3;
        end else if (dscore <= 4'd5) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_P3:    state_d = S_BEVAL;
      S_BEVAL: state_d = dealer_draws(dscore, pcard3) ? S_D3 : S_DONE;
      S_D3:    state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RESET;
    endcase
  end

  // Moore outputs decoded from the next state so they can be registered.
  always_comb begin
    loads_d = 6'b000000;
    done_d  = 1'b0;
    case (state_d)
      S_P1:    loads_d = 6'b100000;
      S_D1:    loads_d = 6'b010000;
      S_P2:    loads_d = 6'b001000;
      S_D2:    loads_d = 6'b000100;
      S_P3:    loads_d = 6'b000010;
      S_D3:    loads_d = 6'b000001;
      S_DONE:  done_d  = 1'b1;
      default: loads_d = 6'b000000;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= S_RESET;
      loads_q <= 6'b000000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      loads_q <= loads_d;
      done_q  <= done_d;
    end
  end

  // Lights follow live scores so a final dealer third card is included.
  always_comb begin
    pwin_s = 1'b0;
    dwin_s = 1'b0;
    if (done_q) begin
      pwin_s = (pscore > dscore) | (pscore == dscore);
      dwin_s = (dscore > pscore) | (pscore == dscore);
    end else begin
      pwin_s = 1'b0;
      dwin_s = 1'b0;
    end
  end

  assign load_pcard1      = loads_q[5];
  assign load_dcard1      = loads_q[4];
  assign load_pcard2      = loads_q[3];
  assign load_dcard2      = loads_q[2];
  assign load_pcard3      = loads_q[1];
  assign load_dcard3      = loads_q[0];
  assign game_over        = done_q;
  assign player_win_light = pwin_s;
  assign dealer_win_light = dwin_s;

endmodule
